// File: rtl/axi_4lite_master.sv
// AXI4-Lite master: one command in, one AXI transaction out, one response back.
// Single outstanding transaction; every output comes straight from a flop.
module axi_4lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    BVALID,
    output logic                    BREADY,
    input  logic [1:0]              BRESP,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    input  logic                    RVALID,
    output logic                    RREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t                 state_q;
    logic                   cmd_ready_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic                   bready_q;
    logic                   arvalid_q;
    logic                   rready_q;
    logic                   rsp_valid_q;
    logic                   rsp_write_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;
    logic [1:0]             rsp_resp_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0]  wstrb_q;
    logic                   aw_done_q;
    logic                   w_done_q;
    logic                   aw_done_d;
    logic                   w_done_d;

    // AW and W finish independently; a flag may be set by this cycle's handshake.
    always_comb begin
        aw_done_d = aw_done_q | (awvalid_q & AWREADY);
        w_done_d  = w_done_q | (wvalid_q & WREADY);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (awvalid_q && AWREADY) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && WREADY) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done_d && w_done_d) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= WR_RESP;
                    end else begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= BRESP;
                        rsp_rdata_q <= '0;
                        rsp_write_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= RDATA;
                        rsp_resp_q  <= RRESP;
                        rsp_write_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AWVALID   = awvalid_q;
    assign AWADDR    = addr_q;
    assign AWPROT    = 3'b000;
    assign WVALID    = wvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign ARADDR    = addr_q;
    assign ARPROT    = 3'b000;
    assign RREADY    = rready_q;

endmodule
